grant_ack_sink: RTL

Manager-side receiver for the TileLink E channel (GrantAck). It owns the pool of sink IDs the manager stamps on outgoing Grant messages. It buffers incoming GrantAck beats in a 2-entry queue and retires each one by freeing its sink ID and notifying the directory. It sits between the link's E-channel input and the manager's D-channel Grant issue logic.

---
 rtl/grant_ack_sink_if.sv | 30 +++
 rtl/grant_ack_sink.sv | 108 ++++++++++
 2 files changed

// File: rtl/grant_ack_sink_if.sv
// E-channel / allocation / retirement signal bundle for grant_ack_sink.
// The slave modport is the sink itself; master is whatever drives it.
interface grant_ack_sink_if #(
    parameter int SINK_BITS = 3
);
    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [SINK_BITS-1:0] alloc_sink;
    logic                 e_valid;
    logic                 e_ready;
    logic [SINK_BITS-1:0] e_bits_sink;
    logic                 free_valid;
    logic                 free_ready;
    logic [SINK_BITS-1:0] free_sink;
    logic [SINK_BITS:0]   outstanding;
    logic                 error;
    logic                 idle;

    modport slave (
        input  alloc_valid, e_valid, e_bits_sink, free_ready,
        output alloc_ready, alloc_sink, e_ready, free_valid, free_sink,
               outstanding, error, idle
    );

    modport master (
        output alloc_valid, e_valid, e_bits_sink, free_ready,
        input  alloc_ready, alloc_sink, e_ready, free_valid, free_sink,
               outstanding, error, idle
    );
endinterface

// File: rtl/grant_ack_sink.sv
// TileLink E-channel sink: owns the sink-ID pool, queues GrantAcks in a
// 2-deep FIFO and retires them by freeing the ID and reporting to the directory.
module grant_ack_sink #(
    parameter int SINK_BITS = 3
) (
    input  logic              clock,
    input  logic              reset,
    grant_ack_sink_if.slave   io
);
    localparam int NUM_IDS = 1 << SINK_BITS;

    logic [NUM_IDS-1:0]   pending_reg;
    logic [NUM_IDS-1:0]   pending_next;
    logic [SINK_BITS-1:0] fifo_mem_reg [2];
    logic                 rd_ptr_reg;
    logic                 wr_ptr_reg;
    logic [1:0]           count_reg;
    logic [1:0]           count_next;
    logic [SINK_BITS:0]   outstanding_reg;
    logic [SINK_BITS:0]   outstanding_next;
    logic                 error_reg;

    logic [SINK_BITS-1:0] alloc_sink_next;
    logic [SINK_BITS-1:0] head_sink;
    logic                 alloc_fire;
    logic                 e_fire;
    logic                 free_fire;
    logic                 retire_ok;

    // Lowest free ID: scanning downward lets the lowest zero win.
    always_comb begin
        alloc_sink_next = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (!pending_reg[i]) begin
                alloc_sink_next = SINK_BITS'(i);
            end
        end
    end

    assign head_sink  = fifo_mem_reg[rd_ptr_reg];
    assign alloc_fire = io.alloc_valid & io.alloc_ready;
    assign e_fire     = io.e_valid & io.e_ready;
    assign free_fire  = io.free_ready & io.free_valid;
    assign retire_ok  = free_fire & pending_reg[head_sink];

    // The allocated ID is always a clear bit and the retired ID a set bit,
    // so the set and clear terms never collide on the same position.
    for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_pending
        assign pending_next[gi] =
            (pending_reg[gi] | (alloc_fire && (alloc_sink_next == SINK_BITS'(gi))))
            & ~(retire_ok && (head_sink == SINK_BITS'(gi)));
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({alloc_fire, retire_ok})
            2'b10:   outstanding_next = outstanding_reg + 1'b1;
            2'b01:   outstanding_next = outstanding_reg - 1'b1;
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({e_fire, free_fire})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_reg     <= '0;
            rd_ptr_reg      <= 1'b0;
            wr_ptr_reg      <= 1'b0;
            count_reg       <= 2'd0;
            outstanding_reg <= '0;
            error_reg       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem_reg[i] <= '0;
            end
        end else begin
            pending_reg     <= pending_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            if (e_fire) begin
                fifo_mem_reg[wr_ptr_reg] <= io.e_bits_sink;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (free_fire) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                if (!pending_reg[head_sink]) begin
                    error_reg <= 1'b1;
                end
            end
        end
    end

    assign io.alloc_ready = ~&pending_reg;
    assign io.alloc_sink  = alloc_sink_next;
    assign io.e_ready     = (count_reg != 2'd2);
    assign io.free_valid  = (count_reg != 2'd0);
    assign io.free_sink   = head_sink;
    assign io.outstanding = outstanding_reg;
    assign io.error       = error_reg;
    assign io.idle        = (outstanding_reg == '0) && (count_reg == 2'd0);
endmodule
